// File: rtl/tpu_pkg.sv
// Shared types and sizes for the unified_buffer write path.
//   LANES  : lanes per buffer row
//   ACC_W  : signed accumulator lane width
//   DATA_W : signed buffer lane width
//   ADDR_W : buffer row address width
package tpu_pkg;

  localparam int LANES  = 32;
  localparam int ACC_W  = 32;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  typedef logic signed [DATA_W-1:0] ub_lane_t;
  typedef logic signed [ACC_W-1:0]  acc_lane_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_DRAIN,
    WB_DONE
  } wb_state_t;

endpackage

// File: rtl/ub_writeback_sat_shift.sv
// sat_shift: one-lane combinational rescale of an accumulator value.
// The lane is arithmetically right-shifted and then clamped to the
// signed DATA_W range.
//   acc_i   in  ACC_W  signed accumulator lane
//   shift_i in  5      right shift amount
//   q_o     out DATA_W signed, saturated lane
module sat_shift
  import tpu_pkg::*;
(
  input  acc_lane_t  acc_i,
  input  logic [4:0] shift_i,
  output ub_lane_t   q_o
);

  localparam acc_lane_t SAT_MAX = acc_lane_t'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam acc_lane_t SAT_MIN = acc_lane_t'(-(64'sd1 <<< (DATA_W-1)));

  function automatic ub_lane_t sat_lane(input acc_lane_t v);
    ub_lane_t res;
    if (v > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
    else                  res = v[DATA_W-1:0];
    return res;
  endfunction

  acc_lane_t w_shifted;

  assign w_shifted = acc_i >>> shift_i;
  assign q_o       = sat_lane(w_shifted);

endmodule

// File: rtl/ub_writeback.sv
// ub_writeback: write-side initiator for unified_buffer.
// Accepts accumulator result rows over valid/ready, quantizes every lane
// (shift + saturate) at accept time, queues rows in a small skid FIFO and
// writes them to the buffer at consecutive (wrapping) addresses.
//   clk_i, rst_i (sync, active-low)
//   start_i, base_addr_i, num_rows_i, shift_i : job setup, sampled in IDLE
//   acc_valid_i, acc_data_i, acc_ready_o      : result row handshake
//   ub_stall_i                                : buffer write port busy
//   ub_write_o, ub_addr_wr_o, ub_data_o       : registered buffer write port
//   busy_o (RUN/DRAIN), done_o (1-cycle pulse after final write)
module ub_writeback
  import tpu_pkg::*;
#(
  parameter int FIFO_D = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   num_rows_i,
  input  logic [4:0]        shift_i,
  input  logic              acc_valid_i,
  input  acc_lane_t         acc_data_i [LANES],
  output logic              acc_ready_o,
  input  logic              ub_stall_i,
  output logic              ub_write_o,
  output logic [ADDR_W-1:0] ub_addr_wr_o,
  output ub_lane_t          ub_data_o [LANES],
  output logic              busy_o,
  output logic              done_o
);

  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_D);
  localparam logic [ADDR_W:0]   ONE_ROW  = (ADDR_W+1)'(1);

  wb_state_t          r_state;
  wb_state_t          w_state_nxt;

  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W:0]    r_num_rows;
  logic [4:0]         r_shift;
  logic [ADDR_W:0]    r_acc_cnt;
  logic [ADDR_W-1:0]  r_wr_cnt;

  ub_lane_t           r_fifo [FIFO_D][LANES];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_fcnt;

  logic               r_ub_write;
  logic [ADDR_W-1:0]  r_ub_addr;
  ub_lane_t           r_ub_data [LANES];

  logic               w_full;
  logic               w_empty;
  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  ub_lane_t           w_q [LANES];

  assign w_full  = (r_fcnt == FULL_CNT);
  assign w_empty = (r_fcnt == '0);
  // Ready is derived from registered state only, never from acc_valid_i.
  assign w_ready = (r_state == WB_RUN) && !w_full && (r_acc_cnt < r_num_rows);
  assign w_push  = acc_valid_i && w_ready;
  assign w_pop   = !w_empty && !ub_stall_i;

  // Quantize stage: per-lane shift + saturate on the incoming row
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sat_shift u_sat (
      .acc_i   (acc_data_i[g]),
      .shift_i (r_shift),
      .q_o     (w_q[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_IDLE: begin
        if (start_i) begin
          w_state_nxt = (num_rows_i == '0) ? WB_DONE : WB_RUN;
        end
      end
      WB_RUN: begin
        if (w_push && ((r_acc_cnt + ONE_ROW) == r_num_rows)) begin
          w_state_nxt = WB_DRAIN;
        end
      end
      WB_DRAIN: begin
        // The pop that empties the FIFO is the final write.
        if (w_empty) begin
          w_state_nxt = WB_DONE;
        end
      end
      WB_DONE: begin
        w_state_nxt = WB_IDLE;
      end
      default: begin
        w_state_nxt = WB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= WB_IDLE;
      r_base     <= '0;
      r_num_rows <= '0;
      r_shift    <= '0;
      r_acc_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fcnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == WB_IDLE) && start_i) begin
        r_base     <= base_addr_i;
        r_num_rows <= num_rows_i;
        r_shift    <= shift_i;
        r_acc_cnt  <= '0;
        r_wr_cnt   <= '0;
      end else begin
        if (w_push) r_acc_cnt <= r_acc_cnt + ONE_ROW;
        if (w_pop)  r_wr_cnt  <= r_wr_cnt + 1'b1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // FIFO storage: contents are only meaningful under r_fcnt, so no reset
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_q;
  end

  // Write stage: registered buffer port; address and data hold while idle
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ub_write <= 1'b0;
      r_ub_addr  <= '0;
      for (int k = 0; k < LANES; k++) r_ub_data[k] <= '0;
    end else begin
      r_ub_write <= w_pop;
      if (w_pop) begin
        r_ub_addr <= r_base + r_wr_cnt;
        r_ub_data <= r_fifo[r_rptr];
      end
    end
  end

  assign acc_ready_o  = w_ready;
  assign ub_write_o   = r_ub_write;
  assign ub_addr_wr_o = r_ub_addr;
  assign ub_data_o    = r_ub_data;
  assign busy_o       = (r_state == WB_RUN) || (r_state == WB_DRAIN);
  assign done_o       = (r_state == WB_DONE);

endmodule

// File: tb/tb_ub_writeback.sv
module tb_ub_writeback;
  import tpu_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W:0]   num_rows_i;
  logic [4:0]        shift_i;
  logic              acc_valid_i;
  acc_lane_t         acc_data_i [LANES];
  logic              acc_ready_o;
  logic              ub_stall_i;
  logic              ub_write_o;
  logic [ADDR_W-1:0] ub_addr_wr_o;
  ub_lane_t          ub_data_o [LANES];
  logic              busy_o;
  logic              done_o;

  always #5 clk_i = ~clk_i;

  ub_writeback #(.FIFO_D(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .num_rows_i   (num_rows_i),
    .shift_i      (shift_i),
    .acc_valid_i  (acc_valid_i),
    .acc_data_i   (acc_data_i),
    .acc_ready_o  (acc_ready_o),
    .ub_stall_i   (ub_stall_i),
    .ub_write_o   (ub_write_o),
    .ub_addr_wr_o (ub_addr_wr_o),
    .ub_data_o    (ub_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle stamp and write/done monitor
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [LANES*DATA_W-1:0] wq_data [$];
  int                      wq_addr [$];
  int                      wq_cyc  [$];
  int                      dq_cyc  [$];
  logic [LANES*DATA_W-1:0] mon_v;

  always @(posedge clk_i) begin
    #1;
    if (ub_write_o === 1'b1) begin
      for (int k = 0; k < LANES; k++) mon_v[k*DATA_W +: DATA_W] = ub_data_o[k];
      wq_data.push_back(mon_v);
      wq_addr.push_back(int'(ub_addr_wr_o));
      wq_cyc.push_back(cyc);
    end
    if (done_o === 1'b1) dq_cyc.push_back(cyc);
  end

  function automatic int lane(input int i, input int k);
    logic [LANES*DATA_W-1:0] v;
    ub_lane_t                x;
    v = wq_data[i];
    x = v[k*DATA_W +: DATA_W];
    return int'(x);
  endfunction

  int s_cyc;
  int acc_in_stall;
  int wr_in_stall;
  int rdy_low_stall;

  task automatic clear_mon();
    wq_data.delete();
    wq_addr.delete();
    wq_cyc.delete();
    dq_cyc.delete();
  endtask

  task automatic drive_row(input int mode, input int r);
    for (int k = 0; k < LANES; k++) begin
      case (mode)
        0: acc_data_i[k] = acc_lane_t'(k);
        1: begin
          case (k)
            0:       acc_data_i[k] = 32'sh0010_0000;
            1:       acc_data_i[k] = -32'sh0010_0000;
            2:       acc_data_i[k] = 32'sh30;
            3:       acc_data_i[k] = -32'sh30;
            default: acc_data_i[k] = '0;
          endcase
        end
        default: acc_data_i[k] = acc_lane_t'(r*1000 + k);
      endcase
    end
  endtask

  // Runs one job from a post-edge point; returns 3 cycles after done_o.
  task automatic run_job(input int base, input int rows, input int sh, input int mode,
                         input int stall_len, input bit glitch, input int abort_after);
    int r;
    int t;
    bit rdy;
    bit vld;
    bit stl;
    bit done_seen;
    clear_mon();
    acc_in_stall  = 0;
    wr_in_stall   = 0;
    rdy_low_stall = 0;
    start_i     = 1'b1;
    base_addr_i = base[ADDR_W-1:0];
    num_rows_i  = rows[ADDR_W:0];
    shift_i     = sh[4:0];
    @(posedge clk_i); #1;
    start_i   = 1'b0;
    s_cyc     = cyc;
    done_seen = done_o;
    r = 0;
    t = 0;
    while (!done_seen && t < 300) begin
      if (abort_after > 0 && r == abort_after) break;
      vld = (r < rows);
      acc_valid_i = vld;
      drive_row(mode, r);
      stl = (t < stall_len);
      ub_stall_i = stl;
      if (glitch && t == 1) begin
        start_i     = 1'b1;
        base_addr_i = 12'd300;
        num_rows_i  = 13'd1;
      end
      rdy = acc_ready_o;
      if (stl && !rdy) rdy_low_stall++;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (rdy && vld) begin
        if (stl) acc_in_stall++;
        r++;
      end
      if (stl && ub_write_o) wr_in_stall++;
      if (done_o) done_seen = 1'b1;
      t++;
    end
    if (abort_after == 0) begin
      chk("job_done_in_budget", longint'(done_seen), 1);
      acc_valid_i = 1'b0;
      ub_stall_i  = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    rst_i       = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    num_rows_i  = '0;
    shift_i     = '0;
    acc_valid_i = 1'b0;
    ub_stall_i  = 1'b0;
    drive_row(0, 0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", longint'(acc_ready_o), 0);
    chk("rst_write", longint'(ub_write_o), 0);
    chk("rst_addr",  longint'(ub_addr_wr_o), 0);
    chk("rst_data0", longint'(ub_data_o[0]), 0);
    chk("rst_busy",  longint'(busy_o), 0);
    chk("rst_done",  longint'(done_o), 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // 1: basic job, lanes = lane index
    run_job(10, 3, 0, 0, 0, 1'b0, 0);
    chk("t1_nwr", wq_addr.size(), 3);
    if (wq_addr.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t1_addr%0d", i), wq_addr[i], 10 + i);
        chk($sformatf("t1_cyc%0d", i), wq_cyc[i], s_cyc + 2 + i);
        chk($sformatf("t1_lane1_r%0d", i), lane(i, 1), 1);
        chk($sformatf("t1_lane31_r%0d", i), lane(i, 31), 31);
      end
    end
    chk("t1_ndone", dq_cyc.size(), 1);
    if (dq_cyc.size() >= 1) chk("t1_done_cyc", dq_cyc[0], s_cyc + 5);
    chk("t1_busy_after", longint'(busy_o), 0);

    // 2: shift by 4 with saturation
    run_job(0, 1, 4, 1, 0, 1'b0, 0);
    chk("t2_nwr", wq_addr.size(), 1);
    if (wq_addr.size() >= 1) begin
      chk("t2_pos_sat", lane(0, 0), 32767);
      chk("t2_neg_sat", lane(0, 1), -32768);
      chk("t2_pos3",    lane(0, 2), 3);
      chk("t2_neg3",    lane(0, 3), -3);
      chk("t2_zero",    lane(0, 4), 0);
    end

    // 3: 5-cycle stall with valid streaming
    run_job(100, 6, 0, 2, 5, 1'b0, 0);
    chk("t3_acc_in_stall", acc_in_stall, 2);
    chk("t3_rdy_low", rdy_low_stall, 3);
    chk("t3_wr_in_stall", wr_in_stall, 0);
    chk("t3_nwr", wq_addr.size(), 6);
    if (wq_addr.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t3_addr%0d", i), wq_addr[i], 100 + i);
        chk($sformatf("t3_lane0_r%0d", i), lane(i, 0), i * 1000);
        chk($sformatf("t3_lane31_r%0d", i), lane(i, 31), i * 1000 + 31);
      end
    end
    chk("t3_ndone", dq_cyc.size(), 1);

    // 4: address wrap
    run_job(4094, 4, 0, 0, 0, 1'b0, 0);
    chk("t4_nwr", wq_addr.size(), 4);
    if (wq_addr.size() >= 4) begin
      chk("t4_addr0", wq_addr[0], 4094);
      chk("t4_addr1", wq_addr[1], 4095);
      chk("t4_addr2", wq_addr[2], 0);
      chk("t4_addr3", wq_addr[3], 1);
    end

    // 5a: zero-row job
    run_job(7, 0, 0, 0, 0, 1'b0, 0);
    chk("t5_zero_nwr", wq_addr.size(), 0);
    chk("t5_zero_ndone", dq_cyc.size(), 1);
    if (dq_cyc.size() >= 1) chk("t5_zero_done_cyc", dq_cyc[0], s_cyc);

    // 5b: start pulse during RUN is ignored
    run_job(200, 4, 0, 2, 0, 1'b1, 0);
    chk("t5_ign_nwr", wq_addr.size(), 4);
    if (wq_addr.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t5_ign_addr%0d", i), wq_addr[i], 200 + i);
    end
    chk("t5_ign_ndone", dq_cyc.size(), 1);

    // 6: reset after 2 of 8 rows accepted
    run_job(500, 8, 0, 2, 0, 1'b0, 2);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("t6_write", longint'(ub_write_o), 0);
    chk("t6_addr",  longint'(ub_addr_wr_o), 0);
    chk("t6_data5", longint'(ub_data_o[5]), 0);
    chk("t6_ready", longint'(acc_ready_o), 0);
    chk("t6_busy",  longint'(busy_o), 0);
    chk("t6_done",  longint'(done_o), 0);
    rst_i = 1'b1;
    clear_mon();
    repeat (10) @(posedge clk_i);
    #1;
    chk("t6_no_wr", wq_addr.size(), 0);
    chk("t6_no_done", dq_cyc.size(), 0);
    acc_valid_i = 1'b0;
    run_job(50, 2, 0, 2, 0, 1'b0, 0);
    chk("t6_fresh_nwr", wq_addr.size(), 2);
    if (wq_addr.size() >= 2) begin
      chk("t6_fresh_addr0", wq_addr[0], 50);
      chk("t6_fresh_addr1", wq_addr[1], 51);
      chk("t6_fresh_lane0_r1", lane(1, 0), 1000);
    end
    chk("t6_fresh_ndone", dq_cyc.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
